// File: rtl/rename_nw_if.sv
// Bundle of the rename stage's group, freelist, commit, flush and dispatch signals.
// master: the surrounding pipeline that drives the group and consumes results.
// slave:  the rename stage itself.
interface rename_nw_if #(
    parameter int WIDTH     = 2,
    parameter int CMT_WIDTH = 2,
    parameter int LREG_W    = 5,
    parameter int PREG_W    = 6,
    parameter int INFO_W    = 128
);
    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_slot_valid;
    logic [WIDTH*LREG_W-1:0]     in_lrs1;
    logic [WIDTH*LREG_W-1:0]     in_lrs2;
    logic [WIDTH*LREG_W-1:0]     in_lrd;
    logic [WIDTH-1:0]            in_src1_is_reg;
    logic [WIDTH-1:0]            in_src2_is_reg;
    logic [WIDTH-1:0]            in_need_to_wb;
    logic [WIDTH*INFO_W-1:0]     in_info;

    logic [WIDTH-1:0]            fl_valid;
    logic [WIDTH*PREG_W-1:0]     fl_prd;
    logic [WIDTH-1:0]            fl_pop;

    logic [CMT_WIDTH-1:0]        cmt_valid;
    logic [CMT_WIDTH*LREG_W-1:0] cmt_lrd;
    logic [CMT_WIDTH*PREG_W-1:0] cmt_prd;

    logic                        flush_valid;

    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_slot_valid;
    logic [WIDTH*PREG_W-1:0]     out_prs1;
    logic [WIDTH*PREG_W-1:0]     out_prs2;
    logic [WIDTH*PREG_W-1:0]     out_prd;
    logic [WIDTH*PREG_W-1:0]     out_old_prd;
    logic [WIDTH*INFO_W-1:0]     out_info;

    modport master (
        output in_valid, in_slot_valid, in_lrs1, in_lrs2, in_lrd,
               in_src1_is_reg, in_src2_is_reg, in_need_to_wb, in_info,
               fl_valid, fl_prd, cmt_valid, cmt_lrd, cmt_prd, flush_valid, out_ready,
        input  in_ready, fl_pop, out_valid, out_slot_valid,
               out_prs1, out_prs2, out_prd, out_old_prd, out_info
    );

    modport slave (
        input  in_valid, in_slot_valid, in_lrs1, in_lrs2, in_lrd,
               in_src1_is_reg, in_src2_is_reg, in_need_to_wb, in_info,
               fl_valid, fl_prd, cmt_valid, cmt_lrd, cmt_prd, flush_valid, out_ready,
        output in_ready, fl_pop, out_valid, out_slot_valid,
               out_prs1, out_prs2, out_prd, out_old_prd, out_info
    );
endinterface

// File: rtl/rename_nw.sv
// N-wide register rename stage: speculative and architectural RATs, intra-group
// RAW/WAW bypass, freelist allocation and a registered valid/ready output stage.
module rename_nw #(
    parameter int WIDTH     = 2,
    parameter int CMT_WIDTH = 2,
    parameter int LREG_W    = 5,
    parameter int PREG_W    = 6,
    parameter int INFO_W    = 128
) (
    input logic        clock,
    input logic        reset_n,
    rename_nw_if.slave bus
);
    localparam int NUM_LREG = 1 << LREG_W;
    localparam int CNT_W    = $clog2(WIDTH + 1);

    logic [PREG_W-1:0] spec_rat  [NUM_LREG];
    logic [PREG_W-1:0] arch_rat  [NUM_LREG];
    logic [PREG_W-1:0] arch_next [NUM_LREG];

    logic [LREG_W-1:0] lrs1 [WIDTH];
    logic [LREG_W-1:0] lrs2 [WIDTH];
    logic [LREG_W-1:0] lrd  [WIDTH];
    logic [PREG_W-1:0] new_prd [WIDTH];
    logic [PREG_W-1:0] prs1    [WIDTH];
    logic [PREG_W-1:0] prs2    [WIDTH];
    logic [PREG_W-1:0] old_prd [WIDTH];
    logic [WIDTH-1:0]  wr;
    logic [CNT_W-1:0]  need;
    logic [CNT_W-1:0]  avail;
    logic              ready;
    logic              fire;

    for (genvar k = 0; k < WIDTH; k++) begin : g_unpack
        assign lrs1[k] = bus.in_lrs1[k*LREG_W +: LREG_W];
        assign lrs2[k] = bus.in_lrs2[k*LREG_W +: LREG_W];
        assign lrd[k]  = bus.in_lrd[k*LREG_W +: LREG_W];
    end

    // Identify writing slots and hand them freelist entries in slot order.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
        need = '0;
        for (int k = 0; k < WIDTH; k++) begin
            wr[k]      = bus.in_slot_valid[k] & bus.in_need_to_wb[k] & (lrd[k] != '0);
            new_prd[k] = '0;
            if (wr[k]) begin
                new_prd[k] = bus.fl_prd[need*PREG_W +: PREG_W];
                need       = need + CNT_W'(1);
            end
        end
    end

    // Count available freelist entries.
    always_comb begin
        avail = '0;
        for (int m = 0; m < WIDTH; m++) avail = avail + CNT_W'(bus.fl_valid[m]);
    end

    // Source and old-destination lookup; the youngest older writer in the group overrides the RAT.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            prs1[k]    = spec_rat[lrs1[k]];
            prs2[k]    = spec_rat[lrs2[k]];
            old_prd[k] = spec_rat[lrd[k]];
            for (int j = 0; j < WIDTH; j++) begin
                if (j < k && wr[j]) begin
                    if (lrd[j] == lrs1[k]) prs1[k]    = new_prd[j];
                    if (lrd[j] == lrs2[k]) prs2[k]    = new_prd[j];
                    if (lrd[j] == lrd[k])  old_prd[k] = new_prd[j];
                end
            end
            if (!bus.in_src1_is_reg[k] || lrs1[k] == '0) prs1[k] = '0;
            if (!bus.in_src2_is_reg[k] || lrs2[k] == '0) prs2[k] = '0;
        end
    end

    // Whole-group handshake: room downstream, enough free pregs, no flush.
    assign ready       = (~bus.out_valid | bus.out_ready) & (need <= avail) & ~bus.flush_valid;
    assign fire        = bus.in_valid & ready;
    assign bus.in_ready = ready;

    // Pop exactly the consumed prefix of the freelist window.
    always_comb begin
        for (int m = 0; m < WIDTH; m++) bus.fl_pop[m] = fire && (CNT_W'(m) < need);
    end

    // Architectural RAT after this cycle's commits; the highest commit index wins on duplicates.
    always_comb begin
        for (int l = 0; l < NUM_LREG; l++) arch_next[l] = arch_rat[l];
        for (int c = 0; c < CMT_WIDTH; c++) begin
            if (bus.cmt_valid[c] && bus.cmt_lrd[c*LREG_W +: LREG_W] != '0)
                arch_next[bus.cmt_lrd[c*LREG_W +: LREG_W]] = bus.cmt_prd[c*PREG_W +: PREG_W];
        end
    end

    // RAT state: commits every cycle, flush restores speculative from architectural, fire renames.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the RATs are architectural state and must come out of reset as the identity map, so this array is reset explicitly.
            for (int l = 0; l < NUM_LREG; l++) begin
                spec_rat[l] <= PREG_W'(l);
                arch_rat[l] <= PREG_W'(l);
            end
        end else begin
            for (int l = 0; l < NUM_LREG; l++) arch_rat[l] <= arch_next[l];
            if (bus.flush_valid) begin
                for (int l = 0; l < NUM_LREG; l++) spec_rat[l] <= arch_next[l];
            end else if (fire) begin
                // Later slots are assigned last, so the youngest writer of an lreg wins.
                for (int k = 0; k < WIDTH; k++) begin
                    if (wr[k]) spec_rat[lrd[k]] <= new_prd[k];
                end
            end
        end
    end

    // Output stage: load on fire, drain on out_ready, otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid      <= 1'b0;
            bus.out_slot_valid <= '0;
            bus.out_prs1       <= '0;
            bus.out_prs2       <= '0;
            bus.out_prd        <= '0;
            bus.out_old_prd    <= '0;
            bus.out_info       <= '0;
        end else if (bus.flush_valid) begin
            bus.out_valid <= 1'b0;
        end else if (fire) begin
            bus.out_valid      <= 1'b1;
            bus.out_slot_valid <= bus.in_slot_valid;
            bus.out_info       <= bus.in_info;
            for (int k = 0; k < WIDTH; k++) begin
                bus.out_prs1[k*PREG_W +: PREG_W]    <= prs1[k];
                bus.out_prs2[k*PREG_W +: PREG_W]    <= prs2[k];
                bus.out_prd[k*PREG_W +: PREG_W]     <= new_prd[k];
                bus.out_old_prd[k*PREG_W +: PREG_W] <= old_prd[k];
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/rename_nw.md
Name: rename_nw

Overview:
- Parametrised N-wide register-rename stage, successor of the 2-wide combinational rename.
- Holds the speculative RAT and the architectural RAT internally as registers.
- Renames a group of up to WIDTH instructions per cycle, resolving intra-group RAW/WAW hazards for any width, and allocates destinations from an external freelist window.
- Registers results into a valid/ready output stage feeding dispatch; flush restores the speculative RAT from the architectural RAT.

Parameters:
WIDTH, 2, instructions per rename group (1..8)
CMT_WIDTH, 2, commit ports updating the architectural RAT
LREG_W, 5, logical register index width (32 lregs)
PREG_W, 6, physical register index width
INFO_W, 128, opaque per-slot sideband (pc, imm, types, predict info) passed through unchanged

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  group valid
in_ready  out  1  group accepted when in_valid&in_ready
in_slot_valid  in  WIDTH  per-slot valid
in_lrs1, in_lrs2, in_lrd  in  WIDTH*LREG_W  logical regs, slot k at [k*LREG_W +: LREG_W]
in_src1_is_reg, in_src2_is_reg, in_need_to_wb  in  WIDTH  per-slot qualifiers
in_info  in  WIDTH*INFO_W  sideband
fl_valid  in  WIDTH  freelist window entries available, prefix-contiguous from bit 0
fl_prd  in  WIDTH*PREG_W  free pregs, entry m at [m*PREG_W +: PREG_W]
fl_pop  out  WIDTH  entries consumed this cycle (prefix mask)
cmt_valid  in  CMT_WIDTH  commit valid, index order = program order
cmt_lrd  in  CMT_WIDTH*LREG_W  committed lrd
cmt_prd  in  CMT_WIDTH*PREG_W  committed prd
flush_valid  in  1  redirect flush
out_valid  out  1  registered group valid
out_ready  in  1  dispatch accepts
out_slot_valid  out  WIDTH  registered per-slot valid
out_prs1, out_prs2, out_prd, out_old_prd  out  WIDTH*PREG_W  renamed regs
out_info  out  WIDTH*INFO_W  registered sideband

Behaviour:
- Reset (async, reset_n=0): both RATs identity (lreg i -> preg i); out_valid=0; all out_* data=0; fl_pop=0.
- Slot k writes iff in_slot_valid[k] & in_need_to_wb[k] & lrd!=0. Need = popcount of writing slots.
- in_ready = (~out_valid | out_ready) & (need <= popcount(fl_valid)) & ~flush_valid. All-or-nothing group; no partial accept.
- fire = in_valid & in_ready. On fire, fl_pop = prefix mask of width need, else 0.
- Writing slot k takes fl_prd entry m, m = number of writing slots j<k.
- prs1 of slot k:
  - 0 if ~src1_is_reg or lrs1=0;
  - else prd of the youngest writing slot j<k with lrd==lrs1;
  - else spec RAT[lrs1].
  - prs2 is resolved the same way.
- old_prd: same bypass rule applied to lrd. out_prd = 0 for non-writing slots.
- On fire, spec RAT[l] <= prd of the youngest writing slot with lrd==l (WAW: later slot wins).
- On each cycle, arch RAT[cmt_lrd] <= cmt_prd for valid commits; duplicate lrd takes the highest index. lrd 0 is ignored.
- Flush (priority over everything):
  - spec RAT <= arch RAT next-state, including same-cycle commits;
  - out_valid <= 0; in_ready=0; fl_pop=0.
- Output register (latency 1):
  - on fire, load all out_* and set out_valid=1;
  - else if out_ready, out_valid <= 0;
  - else hold all outputs stable.
  - out_* data holds its value when out_valid=0.
- RAT lookups use pre-fire state; writes are visible from the next group.

Test Plan:
- Reset, WIDTH=2, single slot add r1,r2,r3, fl_prd0=40 -> out_prs1=2, out_prs2=3, out_prd=40, out_old_prd=1, fl_pop=01; next group reads r1 -> prs=40.
- WIDTH=4 chain r1=r2; r3=r1; r1=r3; r4=r1, fl 50..53 -> prd 50,51,52,53; prs1 2,50,51,52; old_prd of slot2=50; spec RAT r1=52, r3=51, r4=53.
- Group needs 3 pregs, fl_valid=0011 -> in_ready=0, fl_pop=0, RAT unchanged; fl_valid=0111 next cycle -> fire, fl_pop=0111.
- out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and outputs stable; out_ready=1 -> new group fires that cycle, registered next.
- Rename r5->60, commit r5->45 in the same cycle as flush_valid -> next cycle spec RAT r5=45, out_valid=0, fl_pop=0 during flush.
- Slot with lrd=0, need_to_wb=1 -> no fl_pop, out_prd=0, RAT unchanged; lrs1=0 -> prs1=0.
